ptn_seq_ctrl: RTL and testbench

Frame-synchronous pattern sequencer that drives the pattern-select input of the pattern generator. It advances the pattern index automatically every `HOLD_FRAMES` frames or applies a host-requested pattern through a request/acknowledge handshake. All pattern changes occur only at a frame boundary, defined as the rising edge of the generator's vertical sync. The block sits between the host/control logic and the pattern generator, in the pixel clock domain.

---
 rtl/ptn_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ptn_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ptn_seq_ctrl.sv
// ptn_seq_ctrl
//
// Purpose:
//   Frame-synchronous pattern sequencer that drives the pattern-select input
//   of the pattern generator. In auto mode it advances the pattern index
//   every HOLD_FRAMES frames. In manual mode it applies a host-requested
//   pattern through a request/acknowledge handshake. Every pattern change
//   happens at a frame boundary, which is the rising edge of i_VSync.
//   The block lives entirely in the pixel clock domain.
//
// Build option:
//   PTN_SEQ_MANUAL_EN
//     - Defined: manual mode, the PEND state, the armed flag and the
//       request latch are built.
//     - Undefined: i_mode, i_req and i_req_ptn are ignored, the block
//       always runs in auto mode, and o_ack and o_busy are tied to 0.
//
// Parameters:
//   PTN_NUM      number of selectable patterns (legal indices 0..PTN_NUM-1)
//   PTN_WIDTH    width of a pattern index
//   HOLD_FRAMES  frames per pattern in auto mode (>= 1)
//   HOLD_WIDTH   width of the hold counter (2**HOLD_WIDTH >= HOLD_FRAMES)
//
// Ports:
//   i_clk          pixel clock
//   i_rst          asynchronous, active-low reset
//   i_en           sequencer enable
//   i_mode         0 = auto, 1 = manual
//   i_VSync        vertical sync; a rising edge marks a frame start
//   i_req          manual pattern request (level)
//   i_req_ptn      requested pattern index
//   o_ack          one-cycle acknowledge that the request was applied
//   o_busy         a request is latched and waiting for a frame boundary
//   o_PTN_type     pattern index to the generator
//   o_frame_start  one-cycle registered pulse at each detected frame start
module ptn_seq_ctrl #(
  parameter int unsigned PTN_NUM     = 4,
  parameter int unsigned PTN_WIDTH   = 2,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned HOLD_WIDTH  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_mode,
  input  logic                 i_VSync,
  input  logic                 i_req,
  input  logic [PTN_WIDTH-1:0] i_req_ptn,
  output logic                 o_ack,
  output logic                 o_busy,
  output logic [PTN_WIDTH-1:0] o_PTN_type,
  output logic                 o_frame_start
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam logic [PTN_WIDTH-1:0]  PTN_LAST  = PTN_WIDTH'(PTN_NUM - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_FRAMES - 1);

  state_e                state_q, state_d;
  logic                  vs_q;
  logic                  primed_q;
  logic [PTN_WIDTH-1:0]  ptn_q, ptn_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic                  frame_start_q, frame_start_d;
  logic                  fs;

`ifdef PTN_SEQ_MANUAL_EN
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  armed_q, armed_d;
  logic [PTN_WIDTH-1:0]  req_ptn_q, req_ptn_d;
`else
  logic                  unused_inputs;
  assign unused_inputs = ^{i_mode, i_req, i_req_ptn};
`endif

  // primed_q masks the first sampled cycle after reset, so a VSync that is
  // already high at reset release does not look like a rising edge.
  assign fs = i_VSync & ~vs_q & primed_q;

  always_comb begin
    state_d       = state_q;
    ptn_d         = ptn_q;
    hold_d        = hold_q;
    frame_start_d = i_en & fs;
`ifdef PTN_SEQ_MANUAL_EN
    ack_d         = 1'b0;
    busy_d        = busy_q;
    req_ptn_d     = req_ptn_q;
    // Re-arm whenever the request line is seen low.
    armed_d       = armed_q | ~i_req;
`endif

    if (!i_en) begin
      state_d = ST_IDLE;
      hold_d  = '0;
`ifdef PTN_SEQ_MANUAL_EN
      busy_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          hold_d  = '0;
        end

        ST_RUN: begin
`ifdef PTN_SEQ_MANUAL_EN
          if (i_mode) begin
            hold_d = '0;
            // An fs seen in the same cycle is not used; the latched
            // index waits for the following frame boundary.
            if (i_req && armed_q) begin
              req_ptn_d = (i_req_ptn > PTN_LAST) ? '0 : i_req_ptn;
              armed_d   = 1'b0;
              busy_d    = 1'b1;
              state_d   = ST_PEND;
            end
          end else
`endif
          if (fs) begin
            if (hold_q == HOLD_LAST) begin
              hold_d = '0;
              ptn_d  = (ptn_q == PTN_LAST) ? '0 : ptn_q + 1'b1;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end

`ifdef PTN_SEQ_MANUAL_EN
        ST_PEND: begin
          if (fs) begin
            ptn_d   = req_ptn_q;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            hold_d  = '0;
            state_d = ST_RUN;
          end
        end
`endif

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= ST_IDLE;
      vs_q          <= 1'b0;
      primed_q      <= 1'b0;
      ptn_q         <= '0;
      hold_q        <= '0;
      frame_start_q <= 1'b0;
`ifdef PTN_SEQ_MANUAL_EN
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      armed_q       <= 1'b1;
      req_ptn_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      vs_q          <= i_VSync;
      primed_q      <= 1'b1;
      ptn_q         <= ptn_d;
      hold_q        <= hold_d;
      frame_start_q <= frame_start_d;
`ifdef PTN_SEQ_MANUAL_EN
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      armed_q       <= armed_d;
      req_ptn_q     <= req_ptn_d;
`endif
    end
  end

  assign o_PTN_type    = ptn_q;
  assign o_frame_start = frame_start_q;
`ifdef PTN_SEQ_MANUAL_EN
  assign o_ack         = ack_q;
  assign o_busy        = busy_q;
`else
  assign o_ack         = 1'b0;
  assign o_busy        = 1'b0;
`endif

endmodule

// File: tb/tb_ptn_seq_ctrl.sv
// tb_ptn_seq_ctrl
//
// Directed testbench for ptn_seq_ctrl with PTN_NUM=4, PTN_WIDTH=3 (so an
// out-of-range index can be requested), HOLD_FRAMES=2, HOLD_WIDTH=2.
// Manual-mode scenarios are compiled in only when PTN_SEQ_MANUAL_EN is
// defined; otherwise the bench checks that requests are ignored.
module tb_ptn_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       vsync;
  logic       req;
  logic [2:0] req_ptn;
  logic       ack;
  logic       busy;
  logic [2:0] ptn;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;
  int fs_count = 0;
  int ack_count = 0;
  int snap;

  ptn_seq_ctrl #(
    .PTN_NUM    (4),
    .PTN_WIDTH  (3),
    .HOLD_FRAMES(2),
    .HOLD_WIDTH (2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_en         (en),
    .i_mode       (mode),
    .i_VSync      (vsync),
    .i_req        (req),
    .i_req_ptn    (req_ptn),
    .o_ack        (ack),
    .o_busy       (busy),
    .o_PTN_type   (ptn),
    .o_frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start) fs_count++;
    if (ack) ack_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise VSync and step past the edge that registers the frame start.
  task automatic vs_rise;
    vsync = 1'b1;
    tick();
  endtask

  // Finish the frame: VSync high one more cycle, then low for three.
  task automatic vs_tail;
    tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame;
    vs_rise();
    vs_tail();
  endtask

  task automatic do_reset;
    en      = 1'b0;
    mode    = 1'b0;
    vsync   = 1'b0;
    req     = 1'b0;
    req_ptn = '0;
    rst_n   = 1'b0;
    repeat (2) tick();
    rst_n   = 1'b1;
    tick();
  endtask

  initial begin
    logic [2:0] auto_seq [8];
    auto_seq = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0};

    // Reset state
    do_reset();
    check("rst_ptn",  ptn, 0);
    check("rst_ack",  ack, 0);
    check("rst_busy", busy, 0);
    check("rst_fs",   frame_start, 0);

    // Auto wrap: 8 frames
    en = 1'b1;
    tick();
    snap = fs_count;
    for (int i = 0; i < 8; i++) begin
      vs_rise();
      check($sformatf("auto_ptn%0d", i), ptn, auto_seq[i]);
      check($sformatf("auto_fs%0d", i), frame_start, 1);
      vs_tail();
    end
    check("auto_fs_count", fs_count - snap, 8);

`ifdef PTN_SEQ_MANUAL_EN
    // Manual request of pattern 2 mid-frame
    mode = 1'b1;
    tick();
    snap = ack_count;
    req = 1'b1;
    req_ptn = 3'd2;
    tick();
    check("man_busy_rise", busy, 1);
    check("man_ptn_hold", ptn, 0);
    vs_rise();
    check("man_ptn", ptn, 2);
    check("man_ack", ack, 1);
    check("man_busy_fall", busy, 0);
    tick();
    check("man_ack_width", ack, 0);
    vsync = 1'b0;
    repeat (3) tick();
    repeat (3) frame();
    check("man_single_ack", ack_count - snap, 1);
    check("man_busy_idle", busy, 0);
    req = 1'b0;
    tick();

    // Out-of-range request clamps to 0
    req = 1'b1;
    req_ptn = 3'd5;
    tick();
    check("oor_busy", busy, 1);
    vs_rise();
    check("oor_ptn", ptn, 0);
    check("oor_ack", ack, 1);
    vs_tail();
    req = 1'b0;
    tick();

    // Request in the same cycle as fs is applied one frame later
    req = 1'b1;
    req_ptn = 3'd3;
    vsync = 1'b1;
    tick();
    check("same_busy", busy, 1);
    check("same_ptn_not_yet", ptn, 0);
    check("same_no_ack", ack, 0);
    check("same_fs", frame_start, 1);
    vs_tail();
    req = 1'b0;
    tick();
    check("same_still_busy", busy, 1);
    vs_rise();
    check("same_ptn", ptn, 3);
    check("same_ack", ack, 1);
    vs_tail();

    // Enable drop while pending
    req = 1'b1;
    req_ptn = 3'd1;
    tick();
    check("drop_busy", busy, 1);
    snap = ack_count;
    en = 1'b0;
    req = 1'b0;
    tick();
    check("drop_busy_clr", busy, 0);
    check("drop_ptn", ptn, 3);
    vs_rise();
    check("drop_no_fs", frame_start, 0);
    vs_tail();
    check("drop_no_ack", ack_count - snap, 0);
    check("drop_ptn_held", ptn, 3);
`else
    // Requests are ignored; auto sequencing continues
    mode = 1'b1;
    req = 1'b1;
    req_ptn = 3'd2;
    tick();
    check("noman_busy", busy, 0);
    vs_rise();
    check("noman_ptn0", ptn, 0);
    check("noman_ack", ack, 0);
    vs_tail();
    vs_rise();
    check("noman_ptn1", ptn, 1);
    vs_tail();
    check("noman_ack_count", ack_count, 0);
`endif

    // Re-enable restarts the hold counter from 0
    do_reset();
    en = 1'b1;
    tick();
    vs_rise();
    check("hold_ptn_a", ptn, 0);
    vs_tail();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    vs_rise();
    check("hold_ptn_b", ptn, 0);
    vs_tail();
    vs_rise();
    check("hold_ptn_c", ptn, 1);
    vs_tail();

    // Asynchronous reset mid-sequence, VSync high at release
    do_reset();
    en = 1'b1;
    tick();
    repeat (6) frame();
    check("pre_rst_ptn", ptn, 3);
    vs_rise();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ptn", ptn, 0);
    check("async_fs", frame_start, 0);
    check("async_ack", ack, 0);
    check("async_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    snap = fs_count;
    repeat (4) tick();
    check("rel_no_fs", fs_count - snap, 0);
    check("rel_ptn", ptn, 0);
    vsync = 1'b0;
    tick();
    vs_rise();
    check("rel_fresh_fs", frame_start, 1);
    vs_tail();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
